chess_clock_core: RTL and testbench

- Time-keeping engine of the chess timer: holds both players' remaining time, counts down the active player once per second, and switches players on move buttons.
- Produces min1/seg1/min2/seg2, the values the display multiplexor consumes, plus flag/state outputs.
- Sits between the debounced button logic and the display path, on the 100 MHz board clock.

---
 rtl/chess_pkg.sv | 69 ++++++
 rtl/chess_tick_gen.sv | 30 +++
 rtl/chess_clock_core.sv | 150 +++++++++++++++
 tb/tb_chess_clock_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types and time arithmetic for the chess clock: state encoding,
// the player time record and its decrement/increment helpers.
package chess_pkg;

    localparam int TIME_W = 6;
    localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;
    localparam logic [TIME_W-1:0] MIN_MAX = 6'd63;

    localparam logic [1:0] ACTIVE_NONE = 2'b00;
    localparam logic [1:0] ACTIVE_P1   = 2'b01;
    localparam logic [1:0] ACTIVE_P2   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RUN_P1,
        RUN_P2,
        PAUSED,
        TIMEOUT
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] mins;
        logic [TIME_W-1:0] secs;
    } ptime_t;

    function automatic logic time_zero(input ptime_t t);
        return (t.mins == '0) && (t.secs == '0);
    endfunction

    // 0:00 is a floor: the clock never wraps below it
    function automatic ptime_t time_dec(input ptime_t t);
        ptime_t r;
        r = t;
        if (t.secs != '0) begin
            r.secs = t.secs - 1'b1;
        end else if (t.mins != '0) begin
            r.mins = t.mins - 1'b1;
            r.secs = SEC_MAX;
        end
        return r;
    endfunction

    // Adds inc seconds with carry into minutes; saturates at 63:59
    function automatic ptime_t time_inc(input ptime_t t, input logic [TIME_W-1:0] inc);
        ptime_t r;
        logic [TIME_W:0] sum;
        r   = t;
        sum = {1'b0, t.secs} + {1'b0, inc};
        if (sum > {1'b0, SEC_MAX}) begin
            if (t.mins == MIN_MAX) begin
                r.secs = SEC_MAX;
            end else begin
                r.mins = t.mins + 1'b1;
                r.secs = TIME_W'(sum - 7'd60);
            end
        end else begin
            r.secs = sum[TIME_W-1:0];
        end
        return r;
    endfunction

    function automatic ptime_t time_preset(input logic [TIME_W-1:0] m);
        ptime_t r;
        r.mins = (m == '0) ? 6'd1 : m;
        r.secs = '0;
        return r;
    endfunction

endpackage

// File: rtl/chess_tick_gen.sv
// Seconds prescaler: counts 0..TICK_CYCLES-1 while enabled; clear has
// priority over counting so a player switch always restarts a full second.
module chess_tick_gen #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/chess_clock_core.sv
// Chess clock time-keeping core: two countdown clocks, run/pause/timeout FSM.
// Define CHESS_FISCHER_INC_EN to add INC_SEC to the mover's clock on each switch.
module chess_clock_core
    import chess_pkg::*;
#(
    parameter int TICK_CYCLES = 100000000,
    parameter int INIT_MIN    = 5,
    parameter int INC_SEC     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       load,
    input  logic [5:0] set_min,
    output logic [5:0] min1,
    output logic [5:0] seg1,
    output logic [5:0] min2,
    output logic [5:0] seg2,
    output logic [1:0] active,
    output logic       flag1,
    output logic       flag2,
    output logic       running
);

`ifdef CHESS_FISCHER_INC_EN
    localparam bit FISCHER = 1'b1;
`else
    localparam bit FISCHER = 1'b0;
`endif
    localparam logic [TIME_W-1:0] INC = TIME_W'(INC_SEC);

    state_t state, state_nx;
    logic   resume_p2, resume_p2_nx;
    ptime_t t1, t2, t1_nx, t2_nx, dec1, dec2;
    logic   flag1_nx, flag2_nx;
    logic   tick_raw, tick, pre_en, pre_clr;

    assign running = (state == RUN_P1) || (state == RUN_P2);
    assign tick    = running && tick_raw;
    // A tick coinciding with pause still completes its second
    assign pre_en  = running && (!pause || tick_raw);
    assign dec1    = time_dec(t1);
    assign dec2    = time_dec(t2);

    chess_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            resume_p2 <= 1'b0;
            t1        <= {TIME_W'(INIT_MIN), 6'd0};
            t2        <= {TIME_W'(INIT_MIN), 6'd0};
            flag1     <= 1'b0;
            flag2     <= 1'b0;
        end else begin
            state     <= state_nx;
            resume_p2 <= resume_p2_nx;
            t1        <= t1_nx;
            t2        <= t2_nx;
            flag1     <= flag1_nx;
            flag2     <= flag2_nx;
        end
    end

    // Priority inside a run state: timeout, then pause, then move button
    always_comb begin
        state_nx     = state;
        resume_p2_nx = resume_p2;
        t1_nx        = t1;
        t2_nx        = t2;
        flag1_nx     = flag1;
        flag2_nx     = flag2;
        pre_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN_P1;
                    pre_clr  = 1'b1;
                end else if (load) begin
                    t1_nx = time_preset(set_min);
                    t2_nx = time_preset(set_min);
                end
            end
            RUN_P1: begin
                if (tick) t1_nx = dec1;
                if (tick && time_zero(dec1)) begin
                    flag1_nx = 1'b1;
                    state_nx = TIMEOUT;
                end else if (pause) begin
                    state_nx     = PAUSED;
                    resume_p2_nx = 1'b0;
                end else if (btn1) begin
                    state_nx = RUN_P2;
                    pre_clr  = 1'b1;
                    if (FISCHER) t1_nx = time_inc(t1_nx, INC);
                end
            end
            RUN_P2: begin
                if (tick) t2_nx = dec2;
                if (tick && time_zero(dec2)) begin
                    flag2_nx = 1'b1;
                    state_nx = TIMEOUT;
                end else if (pause) begin
                    state_nx     = PAUSED;
                    resume_p2_nx = 1'b1;
                end else if (btn2) begin
                    state_nx = RUN_P1;
                    pre_clr  = 1'b1;
                    if (FISCHER) t2_nx = time_inc(t2_nx, INC);
                end
            end
            PAUSED: begin
                if (pause) state_nx = resume_p2 ? RUN_P2 : RUN_P1;
            end
            TIMEOUT: begin
                if (load) begin
                    t1_nx    = time_preset(set_min);
                    t2_nx    = time_preset(set_min);
                    flag1_nx = 1'b0;
                    flag2_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        active = ACTIVE_NONE;
        if (state == RUN_P1) active = ACTIVE_P1;
        if (state == RUN_P2) active = ACTIVE_P2;
    end

    assign min1 = t1.mins;
    assign seg1 = t1.secs;
    assign min2 = t2.mins;
    assign seg2 = t2.secs;

endmodule

// File: tb/tb_chess_clock_core.sv
// Scoreboard bench for chess_clock_core with TICK_CYCLES = 4 and INIT_MIN = 1;
// expected snapshots are queued by the stimulus and compared by a negedge monitor.
module tb_chess_clock_core;

    localparam int TICK = 4;

`ifdef CHESS_FISCHER_INC_EN
    localparam logic [5:0] A_M = 6'd1, A_S = 6'd0;
    localparam logic [5:0] B_M = 6'd1, B_S = 6'd0;
    localparam logic [5:0] C_S = 6'd31;
    localparam logic [5:0] D_M = 6'd1, D_S = 6'd2;
    localparam int TO_30 = 30, TO_1 = 30;
`else
    localparam logic [5:0] A_M = 6'd0, A_S = 6'd58;
    localparam logic [5:0] B_M = 6'd0, B_S = 6'd58;
    localparam logic [5:0] C_S = 6'd29;
    localparam logic [5:0] D_M = 6'd0, D_S = 6'd58;
    localparam int TO_30 = 28, TO_1 = 28;
`endif

    logic       clk = 1'b0;
    logic       rst, start, pause, btn1, btn2, load;
    logic [5:0] set_min;
    logic [5:0] min1, seg1, min2, seg2;
    logic [1:0] active;
    logic       flag1, flag2, running;

    typedef struct packed {
        logic [5:0] m1, s1, m2, s2;
        logic [1:0] act;
        logic       f1, f2, run;
    } snap_t;

    snap_t act_snap;
    snap_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    chess_clock_core #(
        .TICK_CYCLES(TICK),
        .INIT_MIN   (1),
        .INC_SEC    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .btn1    (btn1),
        .btn2    (btn2),
        .load    (load),
        .set_min (set_min),
        .min1    (min1),
        .seg1    (seg1),
        .min2    (min2),
        .seg2    (seg2),
        .active  (active),
        .flag1   (flag1),
        .flag2   (flag2),
        .running (running)
    );

    assign act_snap = {min1, seg1, min2, seg2, active, flag1, flag2, running};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act_snap === e) begin
                passes++;
            end else begin
                $display("[TB] FAIL %s: got P1 %0d:%0d P2 %0d:%0d active=%b flag1=%b flag2=%b running=%b, expected P1 %0d:%0d P2 %0d:%0d active=%b flag1=%b flag2=%b running=%b",
                         n, act_snap.m1, act_snap.s1, act_snap.m2, act_snap.s2, act_snap.act,
                         act_snap.f1, act_snap.f2, act_snap.run,
                         e.m1, e.s1, e.m2, e.s2, e.act, e.f1, e.f2, e.run);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic b1, input logic b2,
                                 input logic l, input logic [5:0] sm);
        start   = s;
        pause   = p;
        btn1    = b1;
        btn2    = b2;
        load    = l;
        set_min = sm;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        btn1  = 1'b0;
        btn2  = 1'b0;
        load  = 1'b0;
    endtask

    task automatic checkOutput(input string n, input logic [5:0] m1, input logic [5:0] s1,
                               input logic [5:0] m2, input logic [5:0] s2, input logic [1:0] act,
                               input logic f1, input logic f2, input logic run);
        exp_q.push_back({m1, s1, m2, s2, act, f1, f2, run});
        name_q.push_back(n);
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL %s: monitor left %0d expectations pending, required 0", n, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
        load = 1'b0; set_min = 6'd0;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("reset", 1, 0, 1, 0, 2'b00, 0, 0, 0);

        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("idle_ignore", 1, 0, 1, 0, 2'b00, 0, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("start", 1, 0, 1, 0, 2'b01, 0, 0, 1);
        waitCycles(3);
        checkOutput("pre_tick", 1, 0, 1, 0, 2'b01, 0, 0, 1);
        waitCycles(1);
        checkOutput("first_tick", 0, 59, 1, 0, 2'b01, 0, 0, 1);
        waitCycles(4);
        checkOutput("second_tick", 0, 58, 1, 0, 2'b01, 0, 0, 1);

        waitCycles(2);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("switch_p2", A_M, A_S, 1, 0, 2'b10, 0, 0, 1);
        waitCycles(3);
        checkOutput("p2_pre_tick", A_M, A_S, 1, 0, 2'b10, 0, 0, 1);
        waitCycles(1);
        checkOutput("p2_first_tick", A_M, A_S, 0, 59, 2'b10, 0, 0, 1);

        waitCycles(2);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("paused", A_M, A_S, 0, 59, 2'b00, 0, 0, 0);
        waitCycles(20);
        checkOutput("paused_frozen", A_M, A_S, 0, 59, 2'b00, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("resume", A_M, A_S, 0, 59, 2'b10, 0, 0, 1);
        waitCycles(1);
        checkOutput("resume_pre_tick", A_M, A_S, 0, 59, 2'b10, 0, 0, 1);
        waitCycles(1);
        checkOutput("resume_tick", A_M, A_S, 0, 58, 2'b10, 0, 0, 1);

        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("switch_p1", A_M, A_S, B_M, B_S, 2'b01, 0, 0, 1);
        waitCycles(TICK * TO_30 + 3);
        checkOutput("p1_at_30", 0, 30, B_M, B_S, 2'b01, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("tick_and_btn", 0, C_S, B_M, B_S, 2'b10, 0, 0, 1);

        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("pause_beats_btn", 0, C_S, B_M, B_S, 2'b00, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("resume_p2", 0, C_S, B_M, B_S, 2'b10, 0, 0, 1);

        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("switch_p1_again", 0, C_S, D_M, D_S, 2'b01, 0, 0, 1);
        waitCycles(TICK * TO_1 + 3);
        checkOutput("p1_at_1", 0, 1, D_M, D_S, 2'b01, 0, 0, 1);
        waitCycles(1);
        checkOutput("timeout", 0, 0, D_M, D_S, 2'b00, 1, 0, 0);
        waitCycles(8);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("timeout_frozen", 0, 0, D_M, D_S, 2'b00, 1, 0, 0);

        applyStimulus(0, 0, 0, 0, 1, 6'd0);
        checkOutput("load_zero", 1, 0, 1, 0, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 6'd3);
        checkOutput("load_idle", 3, 0, 3, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("start_3min", 3, 0, 3, 0, 2'b01, 0, 0, 1);
        waitCycles(4);
        checkOutput("borrow", 2, 59, 3, 0, 2'b01, 0, 0, 1);

        waitCycles(2);
        rst = 1'b1;
        start = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        start = 1'b0;
        checkOutput("mid_reset", 1, 0, 1, 0, 2'b00, 0, 0, 0);

`ifdef CHESS_FISCHER_INC_EN
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitCycles(4);
        checkOutput("fischer_pre", 0, 59, 1, 0, 2'b01, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("fischer_wrap", 1, 1, 1, 0, 2'b10, 0, 0, 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
